sr_ff_sequencer: RTL and testbench

//   Drives the s/r inputs of one SR flip-flop through a fixed 4-step pattern, one step per prescaler

---
 rtl/sr_ff_sequencer_pkg.sv | 32 +++
 rtl/sr_ff_sequencer_if.sv | 35 +++
 rtl/sr_ff_sequencer_tick_prescaler.sv | 29 ++
 rtl/sr_ff_sequencer.sv | 154 +++++++++++++++
 tb/tb_sr_ff_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_ff_sequencer_pkg.sv
// rtl/sr_ff_sequencer_pkg.sv - shared types, drive codes and step tables for the SR flip-flop sequencer
package sr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_CHECK,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;

  // Index 0 is the rightmost element: steps 0..3 drive RST, SET, HOLD, RST.
  localparam logic [3:0][1:0] SR_PATTERN = {SR_RST, SR_HOLD, SR_SET, SR_RST};
  localparam logic [3:0]      EXP_Q      = 4'b0110;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] pattern_at(input logic [1:0] slot);
    return SR_PATTERN[slot];
  endfunction

  function automatic logic exp_q_at(input logic [1:0] slot);
    return EXP_Q[slot];
  endfunction

endpackage

// File: rtl/sr_ff_sequencer_if.sv
// rtl/sr_ff_sequencer_if.sv - control, flip-flop drive/feedback and status bundle of the sequencer
interface sr_ff_sequencer_if
  import sr_seq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int ERR_W     = 8
);
  localparam int IDX_W = idx_width(NUM_STEPS);

  logic             start;
  logic             stop;
  logic             step_mode;
  logic             step;
  logic             q;
  logic             q_bar;
  logic             s;
  logic             r;
  logic             busy;
  logic             done;
  logic             tick;
  logic [IDX_W-1:0] step_idx;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output start, stop, step_mode, step, q, q_bar,
    input  s, r, busy, done, tick, step_idx, err, err_count
  );

  modport slave (
    input  start, stop, step_mode, step, q, q_bar,
    output s, r, busy, done, tick, step_idx, err, err_count
  );

endinterface

// File: rtl/sr_ff_sequencer_tick_prescaler.sv
// rtl/sr_ff_sequencer_tick_prescaler.sv - free-running clock-enable generator, one tick per DIVISOR cycles
module tick_prescaler #(
  parameter int DIVISOR = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int               CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/sr_ff_sequencer.sv
// rtl/sr_ff_sequencer.sv - steps an SR flip-flop through a fixed s/r pattern and checks q/q_bar
// Optional checker: define SR_SEQ_CHECK_EN to enable err/err_count; otherwise they read 0.
module sr_ff_sequencer
  import sr_seq_pkg::*;
#(
  parameter int DIVISOR   = 100_000_000,
  parameter int NUM_STEPS = 8,
  parameter int ERR_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  sr_ff_sequencer_if.slave    bus
);
  localparam int               IDX_W    = idx_width(NUM_STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  logic tick_w;

  tick_prescaler #(
    .DIVISOR(DIVISOR)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick_w)
  );

  seq_state_t       state_q, state_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             adv;
  logic [1:0]       slot;

`ifdef SR_SEQ_CHECK_EN
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             exp_q;
  logic             mismatch;
`endif

  always_comb begin
    adv     = bus.step_mode ? bus.step : tick_w;
    slot    = 2'(idx_q);
    state_d = state_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    done_d  = 1'b0;
    idx_d   = idx_q;
`ifdef SR_SEQ_CHECK_EN
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    exp_q     = exp_q_at(slot);
    mismatch  = (bus.q != exp_q) || (bus.q_bar != !exp_q);
`endif

    // Stop outranks everything, including a start in the same cycle.
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_DRIVE;
            idx_d   = '0;
`ifdef SR_SEQ_CHECK_EN
            err_d     = 1'b0;
            err_cnt_d = '0;
`endif
          end
        end
        ST_DRIVE: begin
          if (adv) begin
            {s_d, r_d} = pattern_at(slot);
            state_d    = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
`ifdef SR_SEQ_CHECK_EN
          if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end
`endif
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
`ifdef SR_SEQ_CHECK_EN
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
`ifdef SR_SEQ_CHECK_EN
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tick     = tick_w;
  assign bus.step_idx = idx_q;

`ifdef SR_SEQ_CHECK_EN
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;
`else
  // Feedback is only consumed by the checker; keep it visibly sunk otherwise.
  wire unused_feedback = bus.q ^ bus.q_bar;
  assign bus.err       = 1'b0;
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_sr_ff_sequencer.sv
// tb/tb_sr_ff_sequencer.sv - scoreboard bench for sr_ff_sequencer driving a behavioural SR flip-flop
module tb_sr_ff_sequencer;
  localparam int DIVISOR   = 4;
  localparam int NUM_STEPS = 8;
  localparam int ERR_W     = 8;
  localparam int P_IDLE = 0, P_DRV = 1, P_SMP = 2, P_CHK = 3, P_DONE = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sr_ff_sequencer_if #(.NUM_STEPS(NUM_STEPS), .ERR_W(ERR_W)) bus ();

  sr_ff_sequencer #(
    .DIVISOR  (DIVISOR),
    .NUM_STEPS(NUM_STEPS),
    .ERR_W    (ERR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic ff_q        = 1'b0;
  logic force_step1 = 1'b0;

  always @(posedge clk) begin
    if (bus.s && !bus.r)      ff_q <= 1'b1;
    else if (bus.r && !bus.s) ff_q <= 1'b0;
  end

  assign bus.q     = (force_step1 && bus.step_idx == 3'd1) ? 1'b0 : ff_q;
  assign bus.q_bar = ~ff_q;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sr(input int i);
    case (i % 4)
      0:       return 2'b01;
      1:       return 2'b10;
      2:       return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic ref_q(input int i);
    return (i % 4 == 1) || (i % 4 == 2);
  endfunction

  // Reference model: state for the current cycle, updated after comparing.
  int         m_phase  = P_IDLE;
  int         m_idx    = 0;
  int         m_cnt    = 0;
  logic       m_err    = 1'b0;
  int         m_errcnt = 0;
  logic [1:0] sbq[$];
  bit         mon_en   = 1'b0;
  int         done_seen = 0;
  int         tick_seen = 0;

  always @(negedge clk) begin
    logic [1:0] exp_sr;
    logic       m_tick;
    logic       adv;
    logic       mis;
    m_tick = (m_cnt == DIVISOR - 1);
    exp_sr = 2'b00;
    if (m_phase == P_SMP && sbq.size() > 0) exp_sr = sbq.pop_front();
    if (mon_en) begin
      if (m_phase == P_SMP && exp_sr == 2'b00 && (m_idx % 4) != 2)
        check_eq("sb_underflow", 32'(sbq.size()), 32'hffff_ffff);
      check_eq("sr", {30'd0, bus.s, bus.r}, {30'd0, exp_sr});
      check_eq("sr_illegal", {31'd0, bus.s & bus.r}, 32'd0);
      check_eq("busy", {31'd0, bus.busy}, {31'd0, m_phase != P_IDLE});
      check_eq("done", {31'd0, bus.done}, {31'd0, m_phase == P_DONE});
      check_eq("tick", {31'd0, bus.tick}, {31'd0, m_tick});
      check_eq("step_idx", 32'(bus.step_idx), 32'(m_idx));
      check_eq("err", {31'd0, bus.err}, {31'd0, m_err});
      check_eq("err_count", 32'(bus.err_count), 32'(m_errcnt));
      assert (!(bus.s && bus.r)) else $error("FAIL sr_both_high at %0t", $time);
      if (bus.done) done_seen++;
      if (bus.tick) tick_seen++;
    end

    adv = bus.step_mode ? bus.step : m_tick;
    if (reset) begin
      m_phase = P_IDLE; m_idx = 0; m_cnt = 0; m_err = 1'b0; m_errcnt = 0;
      sbq.delete();
    end else begin
      m_cnt = m_tick ? 0 : m_cnt + 1;
      if (bus.stop) begin
        m_phase = P_IDLE;
        sbq.delete();
      end else begin
        case (m_phase)
          P_IDLE: if (bus.start) begin
            m_phase = P_DRV; m_idx = 0; m_err = 1'b0; m_errcnt = 0;
            sbq.delete();
            for (int i = 0; i < NUM_STEPS; i++) sbq.push_back(ref_sr(i));
          end
          P_DRV: if (adv) m_phase = P_SMP;
          P_SMP: m_phase = P_CHK;
          P_CHK: begin
`ifdef SR_SEQ_CHECK_EN
            mis = (bus.q != ref_q(m_idx)) || (bus.q_bar != !ref_q(m_idx));
`else
            mis = 1'b0;
`endif
            if (mis) begin
              m_err = 1'b1;
              if (m_errcnt < 255) m_errcnt++;
            end
            if (m_idx == NUM_STEPS - 1) m_phase = P_DONE;
            else begin
              m_idx++;
              m_phase = P_DRV;
            end
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!bus.done && k < lim) begin
      cyc(1);
      k++;
    end
    if (k >= lim) check_eq(tag, 32'd0, 32'd1);
    cyc(1);
  endtask

  initial begin
    int base;
    int k;
    bus.start = 1'b0; bus.stop = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;

    // 1: reset and idle
    cyc(1);
    mon_en = 1'b1;
    cyc(2);
    reset = 1'b0;
    tick_seen = 0;
    cyc(20);
    check_eq("t1_ticks_in_20", 32'(tick_seen), 32'd5);

    // 2: tick-paced run; a step pulse with step_mode=0 must be ignored
    base = done_seen;
    pulse_start();
    cyc(5);
    bus.step = 1'b1; cyc(1); bus.step = 1'b0;
    wait_done("t2_done_timeout", 100);
    check_eq("t2_done_once", 32'(done_seen - base), 32'd1);
    check_eq("t2_busy_after", {31'd0, bus.busy}, 32'd0);
    check_eq("t2_sb_drained", 32'(sbq.size()), 32'd0);
    check_eq("t2_err", {31'd0, bus.err}, 32'd0);

    // 3: manual stepping, then stop mid-run
    base = done_seen;
    bus.step_mode = 1'b1;
    pulse_start();
    repeat (3) begin
      cyc(2);
      bus.step = 1'b1; cyc(1); bus.step = 1'b0;
      cyc(2);
    end
    cyc(6);
    check_eq("t3_idx", 32'(bus.step_idx), 32'd3);
    check_eq("t3_no_done", 32'(done_seen - base), 32'd0);
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    check_eq("t3_stop_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t3_stop_sr", {30'd0, bus.s, bus.r}, 32'd0);
    bus.step_mode = 1'b0;

    // 4: corrupt q during step 1 check
    force_step1 = 1'b1;
    pulse_start();
    wait_done("t4_done_timeout", 100);
    force_step1 = 1'b0;
`ifdef SR_SEQ_CHECK_EN
    check_eq("t4_err", {31'd0, bus.err}, 32'd1);
    check_eq("t4_err_count", 32'(bus.err_count), 32'd1);
`else
    check_eq("t4_err", {31'd0, bus.err}, 32'd0);
    check_eq("t4_err_count", 32'(bus.err_count), 32'd0);
`endif
    pulse_start();
    check_eq("t4_err_clr", {31'd0, bus.err}, 32'd0);
    check_eq("t4_cnt_clr", 32'(bus.err_count), 32'd0);
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;

    // 5: start+stop together, then start while busy
    bus.start = 1'b1; bus.stop = 1'b1; cyc(1);
    bus.start = 1'b0; bus.stop = 1'b0;
    check_eq("t5_startstop_idle", {31'd0, bus.busy}, 32'd0);
    base = done_seen;
    pulse_start();
    cyc(9);
    pulse_start();
    wait_done("t5_done_timeout", 100);
    check_eq("t5_done_once", 32'(done_seen - base), 32'd1);
    check_eq("t5_final_idx", 32'(bus.step_idx), 32'(NUM_STEPS - 1));

    // 6: reset while SAMPLE drives SET
    pulse_start();
    k = 0;
    while ({bus.s, bus.r} != 2'b10 && k < 100) begin
      cyc(1);
      k++;
    end
    check_eq("t6_saw_set", {30'd0, bus.s, bus.r}, 32'd2);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check_eq("t6_sr", {30'd0, bus.s, bus.r}, 32'd0);
    check_eq("t6_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t6_idx", 32'(bus.step_idx), 32'd0);
    check_eq("t6_tick", {31'd0, bus.tick}, 32'd0);
    cyc(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
